// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU): 33 cycles start-to-done, 1 cycle for /0 and signed overflow.
// Accepts start only when idle and not busy; a start that arrives otherwise is dropped, and there is no output stall.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_STEP = 6'(XLEN - 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            is_signed;
  logic            sign1, sign2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, sgn_ovf, accept;
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] sel_val, final_val;
  logic            sel_neg;

  // op[0]=0 selects the signed flavours, op[1]=1 selects the remainder.
  assign is_signed = ~op[0];
  assign sign1     = is_signed & rs1_val[XLEN-1];
  assign sign2     = is_signed & rs2_val[XLEN-1];
  assign abs1      = sign1 ? (~rs1_val + 1'b1) : rs1_val;
  assign abs2      = sign2 ? (~rs2_val + 1'b1) : rs2_val;
  assign div_zero  = (rs2_val == '0);
  assign sgn_ovf   = is_signed && (rs1_val == INT_MIN) && (rs2_val == '1);
  assign accept    = (state_q == IDLE) && start && !busy_q;

  // rem_q[XLEN] is zero by construction; folding it in keeps the step a plain 33-bit compare.
  assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign fits    = rem_q[XLEN] | (shifted >= {1'b0, dvsr_q});

  assign sel_val   = op_q[1] ? rem_q[XLEN-1:0] : quo_q;
  assign sel_neg   = op_q[1] ? rneg_q : qneg_q;
  assign final_val = sel_neg ? (~sel_val + 1'b1) : sel_val;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          op_d   = op;
          rd_d   = rd_in;
          busy_d = 1'b1;
          cnt_d  = '0;
          dvsr_d = abs2;
          if (div_zero || sgn_ovf) begin
            // Preload the architectural answers so DONE needs no special case.
            quo_d   = div_zero ? '1 : INT_MIN;
            rem_d   = div_zero ? {1'b0, rs1_val} : '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DONE;
          end else begin
            quo_d   = abs1;
            rem_d   = '0;
            qneg_d  = sign1 ^ sign2;
            rneg_d  = sign1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        busy_d = 1'b1;
        rem_d  = fits ? diff : shifted;
        quo_d  = {quo_q[XLEN-2:0], fits};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d   = 1'b1;
        done_d   = 1'b1;
        we_d     = (rd_q != 5'd0);
        result_d = final_val;
        rd_out_d = rd_q;
        state_d  = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random divide requests; expectations come from a behavioural model via a scoreboard queue.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .we      (we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] q;
    logic [31:0] r;
    logic        sgn;
    sgn = !o[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; e.lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e.lat = 1;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); e.lat = 33;
    end else begin
      q = a / b; r = a % b; e.lat = 33;
    end
    e.res = o[1] ? r : q;
    e.rd  = rd;
    e.we  = (rd != 5'd0);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drives start at the current negedge so it is sampled on the next rising edge.
  task automatic issue_now(input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    sb.push_back(model(o, a, b, rd));
    cyc = 0;
    tick();
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    tick();
    issue_now(o, a, b, rd);
  endtask

  task automatic wait_done(input string tag, input bit poke_on_done);
    exp_t e;
    while (done !== 1'b1 && cyc < 80) tick();
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc - 1), 32'(e.lat));
    check({tag, "_result"},  result, e.res);
    check({tag, "_rd_out"},  32'(rd_out), 32'(e.rd));
    check({tag, "_we"},      32'(we), 32'(e.we));
    check({tag, "_busy"},    32'(busy), 32'd1);
    if (poke_on_done) begin
      start = 1'b1; op = 2'b01; rs1_val = 32'd77; rs2_val = 32'd7; rd_in = 5'd20;
    end
    tick();
    start = 1'b0;
    if (poke_on_done) check({tag, "_no_accept"}, 32'(busy), 32'd0);
    check({tag, "_done_low"},    32'(done), 32'd0);
    check({tag, "_we_low"},      32'(we), 32'd0);
    check({tag, "_result_hold"}, result, e.res);
    check({tag, "_rd_hold"},     32'(rd_out), 32'(e.rd));
  endtask

  initial begin
    exp_t        dropped;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd_in = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_we",     32'(we), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    issue(2'b01, 32'd100, 32'd7, 5'd5);                 wait_done("divu_100_7", 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);           wait_done("rem_m7_2", 1'b0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);           wait_done("div_m7_2", 1'b0);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd21);          wait_done("div_7_m2", 1'b0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd22);          wait_done("rem_7_m2", 1'b0);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);   wait_done("div_ovf", 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);   wait_done("rem_ovf", 1'b0);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23);  wait_done("divu_big", 1'b0);
    issue(2'b01, 32'd9, 32'd0, 5'd8);                   wait_done("divu_by0", 1'b0);
    issue(2'b11, 32'd9, 32'd0, 5'd9);                   wait_done("remu_by0", 1'b0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd10);          wait_done("div_by0", 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd11);          wait_done("rem_by0", 1'b0);
    issue(2'b01, 32'd6, 32'd3, 5'd0);                   wait_done("rd0_no_we", 1'b0);

    // A second start mid-calculation must not disturb the operation in flight.
    issue(2'b01, 32'd1000, 32'd7, 5'd12);
    repeat (5) tick();
    start = 1'b1; op = 2'b00; rs1_val = 32'd123; rs2_val = 32'd5; rd_in = 5'd13;
    tick();
    start = 1'b0;
    wait_done("ignore_start", 1'b0);

    issue(2'b01, 32'd50, 32'd5, 5'd14);                 wait_done("start_on_done", 1'b1);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      issue(ro, ra, rb, 5'(i + 1));
      wait_done("random", 1'b0);
    end

    // Asynchronous reset in the middle of CALC aborts the divide.
    issue(2'b01, 32'd1000, 32'd3, 5'd15);
    repeat (9) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_done",   32'(done), 32'd0);
    check("midrst_we",     32'(we), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd_out", 32'(rd_out), 32'd0);
    dropped = sb.pop_front();
    tick();
    check("midrst_hold_done", 32'(done), 32'd0);
    rst = 1'b1;
    issue_now(2'b01, 32'h20, 32'd8, 5'd16);
    wait_done("post_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
